// File: rtl/pc_gen_unit.sv
// Program-counter generator for the IF stage: boot sequencing, trap/branch redirect,
// one-entry pending-redirect buffer under backpressure, and misaligned-target rejection.
module pc_gen_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
  parameter logic [ADDR_W-1:0]    TRAP_VEC   = ADDR_W'(32'h0000_0100),
  parameter int unsigned          STEP       = 4,
  parameter int unsigned          ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              fetch_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              trap_flag_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              pend_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  // ALIGN_BITS = 0 yields an all-zero mask, which disables the check.
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] StepInc   = ADDR_W'(STEP);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

  logic adv;
  logic tgt_misaligned;

  assign adv            = fetch_ready_i & ~stall_i;
  assign tgt_misaligned = |(branch_target_i & AlignMask);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_d          = pend_q;
    pend_tgt_d      = pend_tgt_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (trap_flag_i) begin
          pc_d   = TRAP_VEC;
          pend_d = 1'b0;
        end else if (branch_flag_i && !tgt_misaligned) begin
          if (adv) begin
            pc_d   = branch_target_i;
            pend_d = 1'b0;
          end else begin
            pend_tgt_d = branch_target_i;
            pend_d     = 1'b1;
          end
        end else begin
          // A rejected target leaves PC/pending flow untouched.
          if (branch_flag_i) begin
            misalign_d      = 1'b1;
            misalign_addr_d = branch_target_i;
          end
          if (pend_q && adv) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else if (adv) begin
            pc_d = pc_q + StepInc;
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StBoot;
      pc_q            <= RESET_VEC;
      pend_q          <= 1'b0;
      pend_tgt_q      <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_q          <= pend_d;
      pend_tgt_q      <= pend_tgt_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc_o            = pc_q;
  assign ce_o            = (state_q == StRun);
  assign pend_o          = pend_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: scoreboarded 32-bit instance plus an 8-bit
// instance for wrap-around and asynchronous reset while a redirect is pending.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        stall, fetch_ready, branch_flag, trap_flag;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        ce, pend, misalign;
  logic [31:0] misalign_addr;

  logic        rst8;
  logic        b_stall, b_ready, b_br, b_trap;
  logic [7:0]  b_tgt;
  logic [7:0]  pc8;
  logic        ce8, pend8, mis8;
  logic [7:0]  maddr8;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    logic [31:0] maddr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic        m_run;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_mis;
  logic [31:0] m_maddr;

  pc_gen_unit u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .fetch_ready_i   (fetch_ready),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .trap_flag_i     (trap_flag),
    .pc_o            (pc),
    .ce_o            (ce),
    .pend_o          (pend),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  pc_gen_unit #(
    .ADDR_W     (8),
    .RESET_VEC  (8'h00),
    .TRAP_VEC   (8'h10),
    .STEP       (4),
    .ALIGN_BITS (2)
  ) u_dut8 (
    .clk             (clk),
    .rst             (rst8),
    .stall_i         (b_stall),
    .fetch_ready_i   (b_ready),
    .branch_flag_i   (b_br),
    .branch_target_i (b_tgt),
    .trap_flag_i     (b_trap),
    .pc_o            (pc8),
    .ce_o            (ce8),
    .pend_o          (pend8),
    .misalign_o      (mis8),
    .misalign_addr_o (maddr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic st, input logic fr, input logic br, input logic tr,
                            input logic [31:0] tgt);
    logic adv;
    logic nmis;
    adv  = fr & ~st;
    nmis = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
    end else if (tr) begin
      m_pc   = 32'h0000_0100;
      m_pend = 1'b0;
    end else if (br && (tgt[1:0] == 2'b00)) begin
      if (adv) begin
        m_pc   = tgt;
        m_pend = 1'b0;
      end else begin
        m_ptgt = tgt;
        m_pend = 1'b1;
      end
    end else begin
      if (br) begin
        nmis    = 1'b1;
        m_maddr = tgt;
      end
      if (m_pend && adv) begin
        m_pc   = m_ptgt;
        m_pend = 1'b0;
      end else if (adv) begin
        m_pc = m_pc + 32'd4;
      end
    end
    m_mis = nmis;
  endtask

  task automatic step(input logic st, input logic fr, input logic br, input logic tr,
                      input logic [31:0] tgt);
    exp_t e;
    stall         = st;
    fetch_ready   = fr;
    branch_flag   = br;
    trap_flag     = tr;
    branch_target = tgt;
    model_edge(st, fr, br, tr, tgt);
    e.pc    = m_pc;
    e.ce    = m_run;
    e.pend  = m_pend;
    e.mis   = m_mis;
    e.maddr = m_maddr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("pc", pc, e.pc);
      check_val("ce", 32'(ce), 32'(e.ce));
      check_val("pend", 32'(pend), 32'(e.pend));
      check_val("misalign", 32'(misalign), 32'(e.mis));
      check_val("misalign_addr", misalign_addr, e.maddr);
    end
  endtask

  initial begin
    logic        r_st, r_fr, r_br, r_tr;
    logic [31:0] r_tgt;
    n_checks = 0;
    n_fail   = 0;
    m_run = 1'b0; m_pc = 32'd0; m_pend = 1'b0; m_ptgt = 32'd0; m_mis = 1'b0; m_maddr = 32'd0;
    rst = 1'b0; rst8 = 1'b0;
    stall = 1'b0; fetch_ready = 1'b1; branch_flag = 1'b0; trap_flag = 1'b0; branch_target = '0;
    b_stall = 1'b0; b_ready = 1'b0; b_br = 1'b0; b_trap = 1'b0; b_tgt = '0;

    #2;
    check_val("rst_pc", pc, 32'd0);
    check_val("rst_ce", 32'(ce), 32'd0);
    check_val("rst_pend", 32'(pend), 32'd0);
    check_val("rst_mis", 32'(misalign), 32'd0);
    check_val("rst_maddr", misalign_addr, 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;

    // Boot, then sequential fetch 0,4,8,C
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    // Taken branch
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    // Branch under stall goes to pending, drains on release
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    // Trap beats branch and clears pending
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h300);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    // Misaligned target
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h42);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    // Misaligned target while pending: pending still drains
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h400);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h41);
    // fetch_ready low holds
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // 32-bit wrap
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      r_st  = ($urandom_range(0, 3) == 0);
      r_fr  = ($urandom_range(0, 3) != 0);
      r_br  = ($urandom_range(0, 2) == 0);
      r_tr  = ($urandom_range(0, 15) == 0);
      r_tgt = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      step(r_st, r_fr, r_br, r_tr, r_tgt);
    end

    // Async reset mid-cycle with a redirect pending
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h500);
    #3;
    rst = 1'b0;
    #1;
    check_val("arst_pc", pc, 32'd0);
    check_val("arst_pend", 32'(pend), 32'd0);
    check_val("arst_ce", 32'(ce), 32'd0);
    check_val("arst_mis", 32'(misalign), 32'd0);

    // 8-bit instance: wrap and async reset while pending
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("w8_boot_ce", 32'(ce8), 32'd1);
    check_val("w8_boot_pc", 32'(pc8), 32'h00);
    b_br = 1'b1; b_tgt = 8'hFC;
    @(posedge clk);
    #1;
    check_val("w8_br_pc", 32'(pc8), 32'hFC);
    b_br = 1'b0;
    @(posedge clk);
    #1;
    check_val("w8_wrap_pc", 32'(pc8), 32'h00);
    @(posedge clk);
    #1;
    check_val("w8_inc_pc", 32'(pc8), 32'h04);
    b_stall = 1'b1; b_br = 1'b1; b_tgt = 8'h20;
    @(posedge clk);
    #1;
    check_val("w8_pend", 32'(pend8), 32'd1);
    check_val("w8_hold_pc", 32'(pc8), 32'h04);
    #3;
    rst8 = 1'b0;
    #1;
    check_val("w8_arst_pc", 32'(pc8), 32'h00);
    check_val("w8_arst_pend", 32'(pend8), 32'd0);
    check_val("w8_arst_ce", 32'(ce8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
